// File: rtl/komandara_k10_pkg.sv
// Shared types for the K10 data-bus slaves: response FSM encoding and
// the wait-counter sizing helper.
package komandara_k10_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dbus_resp_state_e;

    // Wait counter must hold WAIT_CYCLES-1 but never collapse to zero width.
    function automatic int cnt_width(input int wait_cycles);
        int w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/k10_dmem_array.sv
// Single-port word storage with byte write enables and a registered read port.
// Contents are deliberately not reset.
module k10_dmem_array #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] mem [WORDS];

    // The read register only loads on reads so it holds through wait cycles.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) begin
                        mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                o_rdata <= mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/k10_dbus_sram.sv
// Data-bus SRAM slave: range check, one-outstanding response FSM and response
// muxing around a k10_dmem_array.
module k10_dbus_sram
    import komandara_k10_pkg::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_dbus_req,
    input  logic             i_dbus_we,
    input  logic [31:0]      i_dbus_addr,
    input  logic [31:0]      i_dbus_wdata,
    input  logic [3:0]       i_dbus_wstrb,
    output logic             o_dbus_gnt,
    output logic             o_dbus_rvalid,
    output logic [31:0]      o_dbus_rdata,
    output logic             o_dbus_err,
    output dbus_resp_state_e o_dbg_state
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CW = cnt_width(WAIT_CYCLES);

    localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI_ADDR = LO_ADDR + 33'(4 * MEM_WORDS);

    dbus_resp_state_e state;
    logic [CW-1:0]    cnt;
    logic             rvalid_q;
    logic             resp_we;
    logic             resp_err;

    logic [32:0]      addr_ext;
    logic [31:0]      offset;
    logic [AW-1:0]    word_idx;
    logic             in_range;
    logic             mem_en;
    logic [31:0]      mem_rdata;

    // Handshake: a request is accepted in any cycle where req and gnt are both
    // high; gnt depends only on req and on the FSM being free (IDLE) or about
    // to retire its response (RESP). Exactly one rvalid follows each accept.
    assign o_dbus_gnt = i_dbus_req && (state == IDLE || state == RESP);

    // Widened compare so a window touching the top of the address map cannot wrap.
    assign addr_ext = {1'b0, i_dbus_addr[31:2], 2'b00};
    assign in_range = (addr_ext >= LO_ADDR) && (addr_ext < HI_ADDR);
    assign offset   = i_dbus_addr - BASE_ADDR;
    assign word_idx = AW'(offset >> 2);
    assign mem_en   = o_dbus_gnt && in_range;

    k10_dmem_array #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_array (
        .i_clk   (i_clk),
        .i_en    (mem_en),
        .i_we    (i_dbus_we),
        .i_be    (i_dbus_wstrb),
        .i_addr  (word_idx),
        .i_wdata (i_dbus_wdata),
        .o_rdata (mem_rdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rvalid_q <= 1'b0;
            resp_we  <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (o_dbus_gnt) begin
                        resp_we  <= i_dbus_we;
                        resp_err <= !in_range;
                        if (WAIT_CYCLES == 0) begin
                            state    <= RESP;
                            rvalid_q <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            cnt      <= CW'(WAIT_CYCLES - 1);
                            rvalid_q <= 1'b0;
                        end
                    end else begin
                        state    <= IDLE;
                        rvalid_q <= 1'b0;
                        resp_we  <= 1'b0;
                        resp_err <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state    <= RESP;
                        rvalid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

    // Read data is only meaningful for an in-range read response.
    assign o_dbus_rvalid = rvalid_q;
    assign o_dbus_err    = rvalid_q && resp_err;
    assign o_dbus_rdata  = (rvalid_q && !resp_err && !resp_we) ? mem_rdata : '0;
    assign o_dbg_state   = state;

endmodule

// File: tb/tb_k10_dbus_sram.sv
// Bench for k10_dbus_sram: one zero-wait instance at the top of the address
// map and one three-wait instance, checked against a word-array model.
module tb_k10_dbus_sram;
    import komandara_k10_pkg::*;

    localparam int          MW = 64;
    localparam logic [31:0] B0 = 32'hFFFF_FF00;
    localparam logic [31:0] B3 = 32'h0000_1000;

    logic             clk;
    logic             rst;
    logic             req   [2];
    logic             we    [2];
    logic [31:0]      addr  [2];
    logic [31:0]      wdata [2];
    logic [3:0]       wstrb [2];
    logic             gnt   [2];
    logic             rvalid[2];
    logic [31:0]      rdata [2];
    logic             err   [2];
    dbus_resp_state_e dbg   [2];

    logic [31:0] base_a [2];
    int          wait_a [2];
    logic [31:0] mem_m  [2][MW];
    logic [32:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    k10_dbus_sram #(.MEM_WORDS(MW), .BASE_ADDR(B0), .WAIT_CYCLES(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_dbus_req(req[0]), .i_dbus_we(we[0]),
        .i_dbus_addr(addr[0]), .i_dbus_wdata(wdata[0]), .i_dbus_wstrb(wstrb[0]),
        .o_dbus_gnt(gnt[0]), .o_dbus_rvalid(rvalid[0]), .o_dbus_rdata(rdata[0]),
        .o_dbus_err(err[0]), .o_dbg_state(dbg[0])
    );

    k10_dbus_sram #(.MEM_WORDS(MW), .BASE_ADDR(B3), .WAIT_CYCLES(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_dbus_req(req[1]), .i_dbus_we(we[1]),
        .i_dbus_addr(addr[1]), .i_dbus_wdata(wdata[1]), .i_dbus_wstrb(wstrb[1]),
        .o_dbus_gnt(gnt[1]), .o_dbus_rvalid(rvalid[1]), .o_dbus_rdata(rdata[1]),
        .o_dbus_err(err[1]), .o_dbg_state(dbg[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed window [base, base+4*MW) in 64-bit arithmetic.
    task automatic model(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st,
                         output logic [32:0] resp);
        longint unsigned wa, lo, hi;
        int idx;
        wa = {32'b0, a[31:2], 2'b00};
        lo = {32'b0, base_a[d]};
        hi = lo + 4 * MW;
        if (wa < lo || wa >= hi) begin
            resp = {1'b1, 32'h0};
        end else begin
            idx = int'((wa - lo) / 4);
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) mem_m[d][idx][8*b +: 8] = wd[8*b +: 8];
                resp = '0;
            end else begin
                resp = {1'b0, mem_m[d][idx]};
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction; entered and left at posedge+1.
    task automatic do_txn(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st,
                          output logic [31:0] rd, output logic er);
        logic [32:0] resp;
        int n;
        int lat;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; wstrb[d] = st;
        #1;
        n = 0;
        while (gnt[d] !== 1'b1 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("txn_gnt", 32'(gnt[d]), 32'd1);
        model(d, w, a, wd, st, resp);
        cyc();
        req[d] = 1'b0;
        lat = 1;
        while (rvalid[d] !== 1'b1 && lat < 10) begin
            cyc();
            lat++;
        end
        chk("txn_latency", lat, wait_a[d] + 1);
        chk("txn_rdata", rdata[d], resp[31:0]);
        chk("txn_err", 32'(err[d]), 32'(resp[32]));
        rd = rdata[d];
        er = err[d];
        cyc();
        chk("txn_rvalid_low", 32'(rvalid[d]), 32'd0);
        chk("txn_idle_rdata", rdata[d], 32'd0);
    endtask

    function automatic logic [31:0] rand_addr(input int d);
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return base_a[d] - 32'(4 * $urandom_range(1, 4));
        if (r == 1) return base_a[d] + 32'(4 * MW) + 32'(4 * $urandom_range(0, 3));
        return base_a[d] + 32'(4 * $urandom_range(0, MW - 1)) + 32'($urandom_range(0, 3));
    endfunction

    // Random back-to-back traffic with req held; responses matched in order.
    task automatic burst(input int d, input int n);
        int issued;
        int cyc_n;
        logic pend;
        logic [32:0] resp;
        logic [32:0] e;
        issued = 0; cyc_n = 0; pend = 1'b0;
        exp_q.delete();
        while ((issued < n || exp_q.size() != 0) && cyc_n < 2000) begin
            if (rvalid[d] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("burst_spurious_rvalid", 32'(rvalid[d]), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("burst_rdata", rdata[d], e[31:0]);
                    chk("burst_err", 32'(err[d]), 32'(e[32]));
                end
            end
            if (issued < n && (pend || $urandom_range(0, 3) != 0)) begin
                if (!pend) begin
                    we[d]    = 1'($urandom_range(0, 1));
                    addr[d]  = rand_addr(d);
                    wdata[d] = $urandom;
                    wstrb[d] = 4'($urandom_range(0, 15));
                    pend     = 1'b1;
                end
                req[d] = 1'b1;
            end else begin
                req[d] = 1'b0;
            end
            #1;
            if (req[d] && gnt[d] === 1'b1) begin
                model(d, we[d], addr[d], wdata[d], wstrb[d], resp);
                exp_q.push_back(resp);
                issued++;
                pend = 1'b0;
            end
            cyc();
            cyc_n++;
        end
        req[d] = 1'b0;
        chk("burst_drain", exp_q.size(), 32'd0);
        chk("burst_issued", issued, n);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [32:0] resp;

        base_a[0] = B0; base_a[1] = B3;
        wait_a[0] = 0;  wait_a[1] = 3;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_gnt", 32'(gnt[d]), 32'd0);
            chk("rst_rvalid", 32'(rvalid[d]), 32'd0);
            chk("rst_rdata", rdata[d], 32'd0);
            chk("rst_err", 32'(err[d]), 32'd0);
            chk("rst_state", 32'(dbg[d]), 32'(IDLE));
        end
        rst = 1'b0;
        cyc();

        // Fill both memories so every model word is defined
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < MW; i++)
                do_txn(d, 1'b1, base_a[d] + 32'(4 * i), $urandom, 4'hF, rd, er);

        // Back-to-back write then read at zero wait
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = B0 + 32'h10;
        wdata[0] = 32'hDEAD_BEEF; wstrb[0] = 4'hF;
        #1;
        chk("b2b_gnt_wr", 32'(gnt[0]), 32'd1);
        model(0, 1'b1, B0 + 32'h10, 32'hDEAD_BEEF, 4'hF, resp);
        cyc();
        we[0] = 1'b0;
        #1;
        chk("b2b_gnt_rd", 32'(gnt[0]), 32'd1);
        chk("b2b_wr_rvalid", 32'(rvalid[0]), 32'd1);
        chk("b2b_wr_rdata", rdata[0], 32'd0);
        chk("b2b_wr_err", 32'(err[0]), 32'd0);
        cyc();
        req[0] = 1'b0;
        chk("b2b_rd_rvalid", 32'(rvalid[0]), 32'd1);
        chk("b2b_rd_rdata", rdata[0], 32'hDEAD_BEEF);
        chk("b2b_rd_err", 32'(err[0]), 32'd0);
        cyc();
        chk("b2b_done", 32'(rvalid[0]), 32'd0);

        // Partial byte write, then an all-disabled strobe
        do_txn(0, 1'b1, B0 + 32'h10, 32'h0000_00AA, 4'b0001, rd, er);
        do_txn(0, 1'b0, B0 + 32'h10, 32'h0, 4'h0, rd, er);
        chk("strb_byte0", rd, 32'hDEAD_BEAA);
        do_txn(0, 1'b1, B0 + 32'h10, 32'h1122_3344, 4'b0000, rd, er);
        chk("strb_none_err", 32'(er), 32'd0);
        do_txn(0, 1'b0, B0 + 32'h12, 32'h0, 4'h0, rd, er);
        chk("strb_none_data", rd, 32'hDEAD_BEAA);

        // Out of range around both window edges
        for (int d = 0; d < 2; d++) begin
            do_txn(d, 1'b1, base_a[d] + 32'(4 * MW - 4), 32'hCAFE_F00D, 4'hF, rd, er);
            do_txn(d, 1'b1, base_a[d] + 32'(4 * MW), 32'h1234_5678, 4'hF, rd, er);
            chk("oor_wr_err", 32'(er), 32'd1);
            chk("oor_wr_rdata", rd, 32'd0);
            do_txn(d, 1'b0, base_a[d] + 32'(4 * MW - 4), 32'h0, 4'h0, rd, er);
            chk("oor_last_word", rd, 32'hCAFE_F00D);
            do_txn(d, 1'b0, base_a[d] - 32'd4, 32'h0, 4'h0, rd, er);
            chk("oor_below_err", 32'(er), 32'd1);
            chk("oor_below_rdata", rd, 32'd0);
        end

        // Three-wait read with req held through the wait
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = B3 + 32'h20; wstrb[1] = 4'h0;
        #1;
        chk("w3_gnt_t", 32'(gnt[1]), 32'd1);
        model(1, 1'b0, B3 + 32'h20, 32'h0, 4'h0, resp);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("w3_gnt_wait", 32'(gnt[1]), 32'd0);
            chk("w3_rvalid_wait", 32'(rvalid[1]), 32'd0);
        end
        cyc();
        req[1] = 1'b0;
        chk("w3_rvalid_t4", 32'(rvalid[1]), 32'd1);
        chk("w3_rdata_t4", rdata[1], resp[31:0]);
        cyc();
        chk("w3_rvalid_t5", 32'(rvalid[1]), 32'd0);

        // Reset in the middle of a pending read drops it
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = B3 + 32'h40;
        #1;
        chk("rstw_gnt", 32'(gnt[1]), 32'd1);
        cyc();
        req[1] = 1'b0;
        cyc();
        #2;
        rst = 1'b1;
        #1;
        chk("rstw_state", 32'(dbg[1]), 32'(IDLE));
        chk("rstw_rvalid", 32'(rvalid[1]), 32'd0);
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("rstw_no_rvalid", 32'(rvalid[1]), 32'd0);
        end
        do_txn(1, 1'b0, B3 + 32'h40, 32'h0, 4'h0, rd, er);
        do_txn(0, 1'b0, B0 + 32'h10, 32'h0, 4'h0, rd, er);
        chk("rst_keeps_mem", rd, 32'hDEAD_BEAA);

        // Randomized pipelined traffic
        burst(0, 80);
        burst(1, 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
